instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Upstream neighbour of control_unit.
- Holds the program counter and issues word fetches to instruction memory over a valid/ready request channel.
- Buffers returned instructions, tagged with their PC, in a small FIFO.
- Presents them to control_unit through a valid/ready handshake.
- Handles PC redirects (branch/jump) by flushing the buffer and discarding stale in-flight responses.

Parameters:
- WORDSIZE, 64: PC and address width.
- INSTRUCTION_SIZE, 32: instruction width.
- RESET_PC, 0: PC value loaded on reset.
- BUFFER_DEPTH, 2: instruction FIFO entries; power of two, ≥2.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- im_req_valid  output  1  fetch request valid.
- im_req_ready  input  1  instruction memory accepts request.
- im_addr  output  WORDSIZE  fetch address (current PC).
- im_resp_valid  input  1  response valid; arrives ≥1 cycle after the accepted request.
- im_resp_data  input  INSTRUCTION_SIZE  fetched instruction.
- redirect_valid  input  1  load new PC, one-cycle pulse.
- redirect_pc  input  WORDSIZE  redirect target.
- instr_valid  output  1  instruction available to control_unit.
- instr_ready  input  1  control_unit consumes instruction.
- instruction  output  INSTRUCTION_SIZE  head-of-FIFO instruction.
- instr_pc  output  WORDSIZE  PC of the head instruction.

Behaviour:
- **Reset:**
  - pc=RESET_PC, state=FETCH, FIFO empty.
  - im_req_valid=0, im_addr=RESET_PC, instr_valid=0, instruction=0, instr_pc=0.
- **Request gating:**
  - At most one outstanding request.
  - im_req_valid=1 only in FETCH, when count + outstanding < BUFFER_DEPTH and redirect_valid=0.
  - im_addr=pc, held stable while valid && !ready.
- **FSM states:**
  - FETCH: on im_req_valid && im_req_ready, latch req_pc=pc, pc<=pc+4, go to WAIT.
  - WAIT: on im_resp_valid, push {req_pc, im_resp_data} into the FIFO and go to FETCH. The FIFO always has room, guaranteed by the gating rule.
  - DROP: on im_resp_valid, discard the data and go to FETCH.
- **Fetch latency:** earliest instr_valid is the cycle after the response is pushed. The FIFO is registered with no bypass.
- **Dequeue:** head pops when instr_valid && instr_ready. Push and pop in the same cycle are allowed; count is unchanged.
- **Redirect (any state, highest priority):**
  - pc<=redirect_pc, FIFO flushed (count=0), instr_valid=0 next cycle.
  - State goes to DROP if a request is outstanding (WAIT, or a request accepted this same cycle), else to FETCH.
  - A response arriving in the same cycle as the redirect is discarded.
  - A pop in the redirect cycle is still a legal consume; control_unit sees instr_valid drop next cycle.
- **PC arithmetic:** modulo 2^WORDSIZE; 0xFFFF_FFFF_FFFF_FFFC + 4 wraps to 0.
- **Full FIFO:** no requests issued, pc held.
- **Empty FIFO:** instr_valid=0; instruction/instr_pc hold the last head value.
- **Reset mid-transaction:** any in-flight response arriving after reset deassert is ignored. State FETCH after reset implies no outstanding request; memory must also be reset.

Optional Feature:
- Macro: IFU_ALIGN_CHECK_EN.
- **Enabled:**
  - Adds output fetch_misaligned (1 bit, reset 0).
  - A redirect_pc with [1:0]≠0 sets fetch_misaligned sticky until the next aligned redirect or reset.
  - While set, no requests are issued.
- **Disabled:** port absent; redirect_pc[1:0] forced to 00.

Decomposition:
- **Shared package rv_pkg:**
  - WORDSIZE, INSTRUCTION_SIZE.
  - PC increment constant INSTR_BYTES=4.
  - RESET_PC default.
  - Fetch FSM state enum typedef {FETCH, WAIT, DROP}.
  - fetch_entry struct {pc, instruction}.
- **Sub-module fetch_buffer:** synchronous FIFO of fetch_entry with flush, count, push/pop, and full/empty outputs.

Test Plan:
- **Reset then free-run:** memory with 1-cycle latency, instr_ready=1. instruction_03 (add) at 0x0, instruction_04 (sub) at 0x4 → instr_pc sequence 0x0, 0x4, 0x8…, first instr_valid 3 cycles after reset release.
- **Backpressure:** instr_ready=0 → exactly BUFFER_DEPTH (2) requests, pc=0x8, im_req_valid=0. Release → entries 0x0, 0x4 emitted in order, fetching resumes at 0x8.
- **Redirect with outstanding request:** redirect_pc=0x100 while in WAIT for 0x4 → 0x4 response dropped, next instr_pc=0x100, no 0x4 delivered.
- **Redirect simultaneous with response and pop:** FIFO flushed, next delivered instr_pc=redirect target.
- **Memory stall:** im_req_ready=0 for 5 cycles → im_addr stable, im_req_valid held high, no duplicate request.
- **PC wrap and alignment:** redirect to 0xFFFF_FFFF_FFFF_FFFC → next fetch at 0x0. With IFU_ALIGN_CHECK_EN, redirect to 0x102 → fetch_misaligned=1 and requests stop.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared fetch-path types: word/instruction widths, PC step, fetch FSM states and
// the {pc, instruction} entry carried by the instruction buffer.
package rv_pkg;

  localparam int WORDSIZE         = 64;
  localparam int INSTRUCTION_SIZE = 32;
  localparam int INSTR_BYTES      = 4;

  localparam logic [WORDSIZE-1:0] RESET_PC = '0;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [WORDSIZE-1:0]         pc;
    logic [INSTRUCTION_SIZE-1:0] instruction;
  } fetch_entry_t;

  // Sequential fetch address; wraps modulo 2^WORDSIZE.
  function automatic logic [WORDSIZE-1:0] step_pc(input logic [WORDSIZE-1:0] pc);
    return pc + WORDSIZE'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Registered synchronous FIFO of fetch entries with flush. The head is held in its own
// register so an empty buffer keeps presenting the last head value.
module fetch_buffer
  import rv_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_entry,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr_nxt;
  logic [CNT_W-1:0] count_nxt;
  fetch_entry_t     head_nxt;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    rd_ptr_nxt = rd_ptr + PTR_W'(do_pop);
    count_nxt  = count + CNT_W'(do_push) - CNT_W'(do_pop);
    head_nxt   = head;
    if (!flush && (count_nxt != '0)) begin
      // An entry pushed into a buffer that is empty after this pop becomes head directly.
      if (do_push && ((count - CNT_W'(do_pop)) == '0)) begin
        head_nxt = push_entry;
      end else begin
        head_nxt = mem[rd_ptr_nxt];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      wr_ptr <= wr_ptr + PTR_W'(do_push);
      count  <= count_nxt;
      head   <= head_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_entry;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC holder and single-outstanding fetch engine feeding control_unit through a small
// instruction buffer. Define IFU_ALIGN_CHECK_EN to add the sticky fetch_misaligned flag.
// WORDSIZE/INSTRUCTION_SIZE must match rv_pkg, which sizes the buffered entries.
module instruction_fetch_unit #(
  parameter int                  WORDSIZE         = rv_pkg::WORDSIZE,
  parameter int                  INSTRUCTION_SIZE = rv_pkg::INSTRUCTION_SIZE,
  parameter logic [WORDSIZE-1:0] RESET_PC         = rv_pkg::RESET_PC,
  parameter int                  BUFFER_DEPTH     = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  output logic                        im_req_valid,
  input  logic                        im_req_ready,
  output logic [WORDSIZE-1:0]         im_addr,
  input  logic                        im_resp_valid,
  input  logic [INSTRUCTION_SIZE-1:0] im_resp_data,
  input  logic                        redirect_valid,
  input  logic [WORDSIZE-1:0]         redirect_pc,
  output logic                        instr_valid,
  input  logic                        instr_ready,
  output logic [INSTRUCTION_SIZE-1:0] instruction,
  output logic [WORDSIZE-1:0]         instr_pc
`ifdef IFU_ALIGN_CHECK_EN
  ,
  output logic                        fetch_misaligned
`endif
);

  import rv_pkg::*;

  localparam int CNT_W = $clog2(BUFFER_DEPTH) + 1;

  fetch_state_e        state;
  fetch_state_e        state_nxt;
  logic [WORDSIZE-1:0] pc;
  logic [WORDSIZE-1:0] pc_nxt;
  logic [WORDSIZE-1:0] req_pc;
  logic [WORDSIZE-1:0] redirect_target;
  logic                outstanding;
  logic                has_room;
  logic                misaligned;
  logic                req_fire;
  logic                push;
  logic                pop;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  fetch_entry_t        push_entry;
  fetch_entry_t        head_entry;

`ifdef IFU_ALIGN_CHECK_EN
  logic misaligned_q;

  assign redirect_target = redirect_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misaligned_q <= 1'b0;
    end else if (redirect_valid) begin
      misaligned_q <= |redirect_pc[1:0];
    end
  end

  assign misaligned       = misaligned_q;
  assign fetch_misaligned = misaligned_q;
`else
  // Without the check, low address bits of a redirect are simply ignored.
  assign redirect_target = redirect_pc & ~WORDSIZE'(3);
  assign misaligned      = 1'b0;
`endif

  assign outstanding  = (state != FETCH);
  assign has_room     = !fifo_full && ((fifo_count + CNT_W'(outstanding)) < CNT_W'(BUFFER_DEPTH));
  assign im_req_valid = !reset && (state == FETCH) && has_room && !redirect_valid && !misaligned;
  assign im_addr      = pc;
  assign req_fire     = im_req_valid && im_req_ready;

  // Responses landing in a redirect cycle belong to the old path and are dropped.
  assign push       = (state == WAIT) && im_resp_valid && !redirect_valid;
  assign pop        = instr_valid && instr_ready;
  assign push_entry = '{pc: req_pc, instruction: im_resp_data};

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    if (redirect_valid) begin
      pc_nxt = redirect_target;
      // A request still in flight after this cycle must have its response swallowed.
      if ((outstanding && !im_resp_valid) || req_fire) begin
        state_nxt = DROP;
      end else begin
        state_nxt = FETCH;
      end
    end else begin
      case (state)
        FETCH: begin
          if (req_fire) begin
            state_nxt = WAIT;
            pc_nxt    = step_pc(pc);
          end
        end
        WAIT, DROP: begin
          if (im_resp_valid) begin
            state_nxt = FETCH;
          end
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) begin
      req_pc <= pc;
    end
  end

  fetch_buffer #(
    .DEPTH (BUFFER_DEPTH)
  ) u_fetch_buffer (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_valid),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head_entry),
    .count      (fifo_count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  assign instr_valid = !fifo_empty;
  assign instruction = head_entry.instruction;
  assign instr_pc    = head_entry.pc;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: directed phases queue the expected
// instruction PCs, a monitor pops and compares each consumed instruction.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        im_req_valid;
  logic        im_req_ready;
  logic [63:0] im_addr;
  logic        im_resp_valid;
  logic [31:0] im_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [63:0] instr_pc;
`ifdef IFU_ALIGN_CHECK_EN
  logic        fetch_misaligned;
`endif

  instruction_fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .im_req_valid   (im_req_valid),
    .im_req_ready   (im_req_ready),
    .im_addr        (im_addr),
    .im_resp_valid  (im_resp_valid),
    .im_resp_data   (im_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instruction    (instruction),
    .instr_pc       (instr_pc)
`ifdef IFU_ALIGN_CHECK_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [63:0] exp_q[$];

  // Memory contents: add x1,x2,x3 at 0x0, sub x1,x2,x3 at 0x4, address-derived elsewhere.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h0:   return 32'h003100B3;
      64'h4:   return 32'h403100B3;
      default: return a[31:0] ^ 32'h5A5A_0013;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  // Instruction memory: fixed per-request latency, one response per accepted request.
  int          mem_lat = 1;
  int          req_count;
  logic        mem_pend;
  int          mem_cnt;
  logic [31:0] mem_data;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_pend  <= 1'b0;
      mem_cnt   <= 0;
      mem_data  <= '0;
      req_count <= 0;
    end else begin
      if (mem_pend) begin
        if (mem_cnt == 0) mem_pend <= 1'b0;
        else mem_cnt <= mem_cnt - 1;
      end
      if (im_req_valid && im_req_ready) begin
        mem_pend  <= 1'b1;
        mem_cnt   <= mem_lat - 1;
        mem_data  <= mem_word(im_addr);
        req_count <= req_count + 1;
      end
    end
  end

  assign im_resp_valid = mem_pend && (mem_cnt == 0);
  assign im_resp_data  = mem_data;

  initial begin : monitor
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!reset && instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_instr: actual pc=%h, required no delivery", instr_pc);
        end else begin
          e = exp_q.pop_front();
          check("instr_pc", instr_pc, e);
          check("instruction", {32'h0, instruction}, {32'h0, mem_word(e)});
        end
      end
    end
  end

  task automatic do_reset(input logic mem_ready);
    @(posedge clk); #1;
    reset          = 1'b1;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    im_req_ready   = mem_ready;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    instr_ready = 1'b1;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    instr_ready = 1'b0;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: actual %0d entries undelivered, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic redirect(input logic [63:0] target);
    redirect_pc    = target;
    redirect_valid = 1'b1;
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int          first;
    int          k;
    int          saved;
    logic        found;

    reset          = 1'b1;
    im_req_ready   = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    instr_ready    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", im_req_valid, 0);
    check("rst_im_addr", im_addr, 64'h0);
    check("rst_instr_valid", instr_valid, 0);
    check("rst_instruction", instruction, 0);
    check("rst_instr_pc", instr_pc, 0);

    // Free run, 1-cycle memory, consumer always ready.
    foreach (exp_q[i]) exp_q.delete(i);
    for (int i = 0; i < 5; i++) exp_q.push_back(64'(i * 4));
    instr_ready = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    first = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (instr_valid) begin
        first = c;
        break;
      end
    end
    check("first_valid_cycle", first, 3);
    drain(200);

    // Backpressure: buffer fills with two entries, pc parks at 0x8.
    do_reset(1'b1);
    repeat (20) @(posedge clk);
    #1;
    check("bp_req_count", req_count, 2);
    check("bp_req_valid", im_req_valid, 0);
    check("bp_pc", im_addr, 64'h8);
    for (int i = 0; i < 4; i++) exp_q.push_back(64'(i * 4));
    drain(200);

    // Redirect while waiting on the 0x4 response.
    mem_lat = 4;
    do_reset(1'b1);
    k = 0;
    while (req_count < 2 && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("redir_setup_reqs", req_count, 2);
    exp_q.push_back(64'h100);
    exp_q.push_back(64'h104);
    redirect(64'h100);
    drain(300);
    mem_lat = 1;

    // Redirect in the same cycle as a response and a pop.
    do_reset(1'b1);
    repeat (10) @(posedge clk);
    #1;
    exp_q.push_back(64'h0);
    drain(50);
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (im_resp_valid && instr_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("sim_setup", found, 1);
    exp_q.push_back(64'h4);
    exp_q.push_back(64'h200);
    exp_q.push_back(64'h204);
    instr_ready = 1'b1;
    redirect(64'h200);
    check("sim_valid_after_flush", instr_valid, 0);
    drain(100);

    // Memory stall: request held with stable address, never duplicated.
    do_reset(1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stall_req_valid", im_req_valid, 1);
      check("stall_im_addr", im_addr, 64'h0);
    end
    @(posedge clk); #1;
    check("stall_no_accept", req_count, 0);
    im_req_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("stall_req_count", req_count, 2);
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h4);
    drain(50);

    // PC wrap at the top of the address space.
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFC);
    exp_q.push_back(64'h0);
    exp_q.push_back(64'h4);
    redirect(64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_im_addr", im_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    drain(100);

`ifdef IFU_ALIGN_CHECK_EN
    redirect(64'h102);
    check("misaligned_set", fetch_misaligned, 1);
    saved = req_count;
    repeat (5) @(posedge clk);
    #1;
    check("misaligned_no_req", req_count, saved);
    check("misaligned_req_valid", im_req_valid, 0);
    exp_q.push_back(64'h200);
    exp_q.push_back(64'h204);
    redirect(64'h200);
    check("misaligned_clear", fetch_misaligned, 0);
    drain(100);
`else
    saved = 0;
    exp_q.push_back(64'h100);
    exp_q.push_back(64'h104);
    redirect(64'h102);
    check("align_forced_addr", im_addr, 64'h100 + 64'(saved));
    drain(100);
`endif

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
